// File: rtl/yarp_mem_arbiter_if.sv
// yarp_mem_arbiter_if: fetch, load/store and memory-port signals of the memory arbiter.
interface yarp_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              imem_req_i;
    logic [ADDR_W-1:0] imem_addr_i;
    logic              imem_gnt_o;
    logic              imem_rvalid_o;
    logic [DATA_W-1:0] imem_rdata_o;
    logic              dmem_req_i;
    logic              dmem_wr_i;
    logic [1:0]        dmem_byte_i;
    logic [ADDR_W-1:0] dmem_addr_i;
    logic [DATA_W-1:0] dmem_wdata_i;
    logic              dmem_gnt_o;
    logic              dmem_rvalid_o;
    logic [DATA_W-1:0] dmem_rdata_o;
    logic              dmem_err_o;
    logic              mem_req_o;
    logic              mem_wr_o;
    logic [3:0]        mem_be_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic              mem_gnt_i;
    logic              mem_rvalid_i;
    logic [DATA_W-1:0] mem_rdata_i;

    modport slave (
        input  imem_req_i, imem_addr_i, dmem_req_i, dmem_wr_i, dmem_byte_i, dmem_addr_i, dmem_wdata_i,
               mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        output imem_gnt_o, imem_rvalid_o, imem_rdata_o, dmem_gnt_o, dmem_rvalid_o, dmem_rdata_o, dmem_err_o,
               mem_req_o, mem_wr_o, mem_be_o, mem_addr_o, mem_wdata_o
    );

    modport master (
        output imem_req_i, imem_addr_i, dmem_req_i, dmem_wr_i, dmem_byte_i, dmem_addr_i, dmem_wdata_i,
               mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        input  imem_gnt_o, imem_rvalid_o, imem_rdata_o, dmem_gnt_o, dmem_rvalid_o, dmem_rdata_o, dmem_err_o,
               mem_req_o, mem_wr_o, mem_be_o, mem_addr_o, mem_wdata_o
    );
endinterface

// File: rtl/yarp_mem_arbiter.sv
// yarp_mem_arbiter: round-robin sharing of one memory port between fetch and load/store, one access in flight.
module yarp_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input logic clk,
    input logic reset,
    yarp_mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, REQ, RESP, ERR} state_t;

    state_t            state;
    logic              owner;
    logic              last_owner;
    logic              wr_q;
    logic [3:0]        be_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [1:0]        off;
    logic [3:0]        dbe;
    logic              dmis;
    logic              pick_d;
    logic              grant;
    logic              done;

    // owner/last_owner: 1 = dmem, 0 = imem
    assign off    = bus.dmem_addr_i[1:0];
    assign dbe    = bus.dmem_byte_i == 2'd0 ? 4'b0001 << off :
                    bus.dmem_byte_i == 2'd1 ? 4'b0011 << off : 4'b1111;
    assign dmis   = bus.dmem_byte_i == 2'd3 || (bus.dmem_byte_i == 2'd1 && off[0]) ||
                    (bus.dmem_byte_i == 2'd2 && off != 2'd0);
    assign pick_d = bus.dmem_req_i && (!bus.imem_req_i || !last_owner);
    // gating with reset keeps the combinational grant quiet while reset is held
    assign grant  = state == IDLE && (bus.imem_req_i || bus.dmem_req_i) && !reset;
    assign done   = state == RESP && bus.mem_rvalid_i;

    assign bus.imem_gnt_o    = grant && !pick_d;
    assign bus.dmem_gnt_o    = grant && pick_d;
    assign bus.imem_rvalid_o = done && !owner;
    assign bus.imem_rdata_o  = done && !owner ? bus.mem_rdata_i : '0;
    assign bus.dmem_rvalid_o = (done && owner) || state == ERR;
    assign bus.dmem_rdata_o  = done && owner && !wr_q ? bus.mem_rdata_i : '0;
    assign bus.dmem_err_o    = state == ERR;
    assign bus.mem_req_o     = state == REQ;
    assign bus.mem_wr_o      = wr_q;
    assign bus.mem_be_o      = be_q;
    assign bus.mem_addr_o    = addr_q;
    assign bus.mem_wdata_o   = wdata_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_owner <= 1'b0;
            wr_q       <= 1'b0;
            be_q       <= 4'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            case (state)
                IDLE: if (grant) begin
                    owner      <= pick_d;
                    last_owner <= pick_d;
                    wr_q       <= pick_d && bus.dmem_wr_i;
                    be_q       <= pick_d ? dbe : 4'b1111;
                    addr_q     <= pick_d ? bus.dmem_addr_i : bus.imem_addr_i & ~ADDR_W'(3);
                    wdata_q    <= pick_d && bus.dmem_wr_i ? bus.dmem_wdata_i << {off, 3'b000} : '0;
                    state      <= pick_d && dmis ? ERR : REQ;
                end
                REQ:  if (bus.mem_gnt_i) state <= RESP;
                RESP: if (bus.mem_rvalid_i) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_yarp_mem_arbiter.sv
// tb_yarp_mem_arbiter: directed and randomized transactions checked against a spec-level access model.
module tb_yarp_mem_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int tests = 0;
    int fails = 0;
    bit last_d = 1'b0;

    yarp_mem_arbiter_if bus ();
    yarp_mem_arbiter dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_gnt"}, {30'b0, bus.imem_gnt_o, bus.dmem_gnt_o}, 32'd0);
        chk({tag, "_rvalid"}, {30'b0, bus.imem_rvalid_o, bus.dmem_rvalid_o}, 32'd0);
        chk({tag, "_rdata"}, bus.imem_rdata_o | bus.dmem_rdata_o, 32'd0);
        chk({tag, "_err"}, {31'b0, bus.dmem_err_o}, 32'd0);
        chk({tag, "_memreq"}, {31'b0, bus.mem_req_o}, 32'd0);
    endtask

    // One whole access: request in IDLE, gd cycles of backpressure, rd idle RESP cycles before the response.
    task automatic txn(input bit wi, input bit wd, input logic [31:0] ia, input logic [31:0] da,
                       input bit dw, input logic [1:0] ds, input logic [31:0] dwd,
                       input int gd, input int rd, input logic [31:0] rdat, input bit glitch);
        bit d, err;
        int off, nbytes;
        logic [31:0] ea, ewd, erd, bemask;
        d = wd && (!wi || !last_d);
        last_d = d;
        off = int'(da[1:0]);
        nbytes = 1 << ds;
        err = d && (ds == 2'd3 || off % nbytes != 0);
        bemask = d ? (((32'd1 << nbytes) - 1) << off) & 32'hF : 32'hF;
        ea = d ? da : ia & ~32'h3;
        ewd = d && dw ? dwd << (8 * off) : 32'd0;
        erd = d && dw ? 32'd0 : rdat;
        @(posedge clk); #1;
        bus.imem_req_i = wi; bus.imem_addr_i = ia;
        bus.dmem_req_i = wd; bus.dmem_wr_i = dw; bus.dmem_byte_i = ds;
        bus.dmem_addr_i = da; bus.dmem_wdata_i = dwd;
        bus.mem_gnt_i = 1'b0; bus.mem_rvalid_i = glitch;
        @(negedge clk);
        chk("imem_gnt", {31'b0, bus.imem_gnt_o}, {31'b0, !d});
        chk("dmem_gnt", {31'b0, bus.dmem_gnt_o}, {31'b0, d});
        chk("idle_rvalid", {30'b0, bus.imem_rvalid_o, bus.dmem_rvalid_o}, 32'd0);
        chk("idle_memreq", {31'b0, bus.mem_req_o}, 32'd0);
        @(posedge clk); #1;
        bus.mem_rvalid_i = 1'b0;
        if (d) begin
            bus.dmem_req_i = 1'b0; bus.dmem_addr_i = $urandom; bus.dmem_wdata_i = $urandom; bus.dmem_wr_i = !dw;
        end else begin
            bus.imem_req_i = 1'b0; bus.imem_addr_i = $urandom;
        end
        if (err) begin
            @(negedge clk);
            chk("err_rvalid", {31'b0, bus.dmem_rvalid_o}, 32'd1);
            chk("err_flag", {31'b0, bus.dmem_err_o}, 32'd1);
            chk("err_rdata", bus.dmem_rdata_o, 32'd0);
            chk("err_memreq", {31'b0, bus.mem_req_o}, 32'd0);
            chk("err_gnt", {30'b0, bus.imem_gnt_o, bus.dmem_gnt_o}, 32'd0);
            chk("err_irvalid", {31'b0, bus.imem_rvalid_o}, 32'd0);
            return;
        end
        for (int k = 0; k <= gd; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            bus.mem_gnt_i = (k == gd);
            bus.mem_rvalid_i = (k == gd) && glitch;
            @(negedge clk);
            chk("mem_req", {31'b0, bus.mem_req_o}, 32'd1);
            chk("mem_addr", bus.mem_addr_o, ea);
            chk("mem_be", {28'b0, bus.mem_be_o}, bemask);
            chk("mem_wr", {31'b0, bus.mem_wr_o}, {31'b0, d && dw});
            chk("mem_wdata", bus.mem_wdata_o, ewd);
            chk("req_gnt", {30'b0, bus.imem_gnt_o, bus.dmem_gnt_o}, 32'd0);
            chk("req_rvalid", {30'b0, bus.imem_rvalid_o, bus.dmem_rvalid_o}, 32'd0);
        end
        for (int k = 0; k <= rd; k++) begin
            @(posedge clk); #1;
            bus.mem_gnt_i = 1'b0;
            bus.mem_rvalid_i = (k == rd);
            bus.mem_rdata_i = k == rd ? rdat : $urandom;
            @(negedge clk);
            chk("resp_memreq", {31'b0, bus.mem_req_o}, 32'd0);
            chk("imem_rvalid", {31'b0, bus.imem_rvalid_o}, {31'b0, k == rd && !d});
            chk("dmem_rvalid", {31'b0, bus.dmem_rvalid_o}, {31'b0, k == rd && d});
            chk("resp_gnt", {30'b0, bus.imem_gnt_o, bus.dmem_gnt_o}, 32'd0);
            if (k == rd) begin
                chk(d ? "dmem_rdata" : "imem_rdata", d ? bus.dmem_rdata_o : bus.imem_rdata_o, erd);
                chk("resp_err", {31'b0, bus.dmem_err_o}, 32'd0);
            end
        end
    endtask

    initial begin
        bus.imem_req_i = 0; bus.imem_addr_i = 0; bus.dmem_req_i = 0; bus.dmem_wr_i = 0;
        bus.dmem_byte_i = 0; bus.dmem_addr_i = 0; bus.dmem_wdata_i = 0;
        bus.mem_gnt_i = 0; bus.mem_rvalid_i = 0; bus.mem_rdata_i = 0;
        @(negedge clk);
        chk_quiet("reset");
        chk("reset_addr", bus.mem_addr_o | bus.mem_wdata_o | {27'b0, bus.mem_wr_o, bus.mem_be_o}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        txn(1, 0, 32'h100, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF, 0);
        txn(0, 1, 0, 32'h203, 1, 2'd0, 32'hAB, 0, 0, 32'h12345678, 0);
        txn(0, 1, 0, 32'h101, 0, 2'd1, 0, 0, 0, 32'h0, 0);
        txn(1, 0, 32'h204, 0, 0, 0, 0, 5, 2, 32'hCAFEF00D, 0);
        txn(0, 1, 0, 32'h302, 1, 2'd1, 32'h1234, 1, 0, 32'h0, 1);
        txn(0, 1, 0, 32'h300, 0, 2'd3, 0, 0, 0, 32'h0, 0);

        // abandon a fetch in RESP with reset, then release and deliver a stale response
        @(posedge clk); #1;
        bus.imem_req_i = 1; bus.imem_addr_i = 32'h40;
        @(posedge clk); #1;
        bus.imem_req_i = 0; bus.mem_gnt_i = 1;
        @(posedge clk); #1;
        bus.mem_gnt_i = 0;
        reset = 1'b1; bus.imem_req_i = 1; bus.dmem_req_i = 1;
        #1;
        chk_quiet("rst_resp");
        chk("rst_fields", bus.mem_addr_o | bus.mem_wdata_o | {27'b0, bus.mem_wr_o, bus.mem_be_o}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0; bus.imem_req_i = 0; bus.dmem_req_i = 0;
        bus.mem_rvalid_i = 1; bus.mem_rdata_i = 32'h55AA55AA;
        @(negedge clk);
        chk_quiet("late_rvalid");
        last_d = 1'b0;

        txn(1, 1, 32'h500, 32'h600, 0, 2'd2, 0, 0, 0, 32'h11111111, 0);
        txn(1, 1, 32'h500, 32'h604, 1, 2'd2, 32'hA5A5A5A5, 1, 1, 32'h22222222, 0);
        txn(1, 1, 32'h508, 32'h604, 1, 2'd2, 32'hA5A5A5A5, 0, 0, 32'h33333333, 0);
        txn(1, 1, 32'h508, 32'h60C, 0, 2'd0, 0, 0, 0, 32'h44444444, 0);

        for (int n = 0; n < 40; n++) begin
            bit wi, wd;
            wi = 1'($urandom_range(0, 1));
            wd = wi ? 1'($urandom_range(0, 1)) : 1'b1;
            txn(wi, wd, $urandom, $urandom, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom,
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom, 1'($urandom_range(0, 1)));
        end

        @(posedge clk); #1;
        bus.imem_req_i = 0; bus.dmem_req_i = 0; bus.mem_rvalid_i = 0;
        @(negedge clk);
        chk_quiet("final");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/yarp_mem_arbiter.md
Name: yarp_mem_arbiter

Overview:
- Shares one memory port between the instruction-fetch requester (imem) and the load/store requester (dmem).
- Data-side requesters are driven by the decoded data_req/data_wr/data_byte controls.
- Arbitrates round-robin, allows one outstanding transaction, generates byte enables and write-lane alignment, and flags misaligned data accesses without touching memory.
- Sits between the core's fetch/LSU front ends and the single-ported memory wrapper.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width (fixed 32 for byte-enable logic)

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
imem_req_i  in  1  fetch request (held until imem_gnt_o)
imem_addr_i  in  ADDR_W  fetch address (word access)
imem_gnt_o  out  1  fetch request accepted (1-cycle pulse)
imem_rvalid_o  out  1  fetch data valid
imem_rdata_o  out  DATA_W  fetch data
dmem_req_i  in  1  data request (held until dmem_gnt_o)
dmem_wr_i  in  1  1=store, 0=load
dmem_byte_i  in  2  access size: BYTE=0, HALF_WORD=1, WORD=2
dmem_addr_i  in  ADDR_W  data byte address
dmem_wdata_i  in  DATA_W  store data, right-aligned
dmem_gnt_o  out  1  data request accepted (1-cycle pulse)
dmem_rvalid_o  out  1  data completion (load data or store ack)
dmem_rdata_o  out  DATA_W  raw word from memory; 0 for stores/errors
dmem_err_o  out  1  misaligned/illegal-size error, valid with dmem_rvalid_o
mem_req_o  out  1  memory request
mem_wr_o  out  1  memory write
mem_be_o  out  4  byte enables
mem_addr_o  out  ADDR_W  byte address (passed unmodified)
mem_wdata_o  out  DATA_W  lane-aligned write data
mem_gnt_i  in  1  memory accepted request
mem_rvalid_i  in  1  memory response
mem_rdata_i  in  DATA_W  memory read data

Behaviour:
- Reset value of every output is 0. State resets to IDLE and last_owner to IMEM.
- FSM states:
  - IDLE: if any request is pending, select one, pulse its gnt_o combinationally this cycle, and register addr/wr/be/wdata/owner.
    - Valid data request: go to REQ.
    - Misaligned data request: go to ERR.
  - REQ: mem_req_o=1, with fields stable from the registers. Stay in REQ until mem_gnt_i=1, then go to RESP.
  - RESP: wait for mem_rvalid_i. On mem_rvalid_i, in the same cycle, assert the owner's rvalid_o with rdata=mem_rdata_i (dmem store: rdata=0). Then go to IDLE.
  - ERR: dmem_rvalid_o=1, dmem_err_o=1, dmem_rdata_o=0 for one cycle, then go to IDLE. No memory access is made.
- Arbitration:
  - Only one requester: it wins.
  - Both requesting: the requester that is not last_owner wins. last_owner updates on every grant.
  - The first tie after reset goes to dmem.
- No grant in REQ/RESP/ERR. The earliest new grant is the cycle after completion, in IDLE.
- Minimum latency: gnt cycle 0, mem_req_o cycle 1, mem_gnt_i cycle 1, response accepted from cycle 2 (rvalid combinational from mem_rvalid_i).
- imem access: wr=0, be=4'b1111. imem_addr_i[1:0]≠0 is forced to an aligned fetch with no error (fetch alignment is not checked here).
- dmem be and alignment, with off=addr[1:0]:
  - BYTE: be=4'b0001<<off.
  - HALF_WORD: be=4'b0011<<off; off[0] must be 0.
  - WORD: be=4'b1111; off must be 0.
  - Size 2'b11: illegal, treated as error.
- Store wdata: mem_wdata_o=dmem_wdata_i<<(8*off). Loads drive mem_wdata_o=0.
- mem_rvalid_i outside RESP is ignored.
- mem_gnt_i and mem_rvalid_i in the same cycle while in REQ: treated as grant only. The response must arrive in a later cycle.
- Asynchronous reset mid-transaction abandons the transaction with no rvalid to either requester. The memory side is assumed to be reset concurrently.
- Requester fields are sampled only at the gnt cycle. Later changes have no effect on the outstanding access.

Test Plan:
- Single fetch: imem_req_i, addr 0x100; mem_gnt_i cycle 1; mem_rvalid_i cycle 3 with 0xDEADBEEF → imem_gnt_o cycle 0; mem_be_o=4'hF, mem_wr_o=0; imem_rvalid_o cycle 3, rdata 0xDEADBEEF.
- Byte store: addr 0x203, wdata 0xAB → mem_be_o=4'b1000, mem_wdata_o=0xAB000000, mem_wr_o=1; dmem_rvalid_o with rdata 0, err 0.
- Simultaneous requests from reset → dmem granted first, imem granted in IDLE after dmem completes. Repeated ties alternate dmem/imem.
- Misaligned HALF_WORD load at 0x101 → dmem_gnt_o, then next cycle dmem_rvalid_o=1, dmem_err_o=1; mem_req_o stays 0 throughout.
- Memory backpressure: mem_gnt_i held low 5 cycles → mem_req_o/addr/be stable all 5 cycles, no new grant; completes normally after mem_gnt_i.
- Reset asserted while in RESP → all outputs 0 immediately. A late mem_rvalid_i after reset release produces no rvalid_o.
